// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the W-stage
// writeback (P) and a multi-cycle unit (M). M results are buffered in a small
// FIFO; P has priority, but a live FIFO head that keeps losing arbitration is
// forced through after MAX_WAIT lost cycles. A P write to rd kills any older
// buffered M result for the same rd (WAW), and the live buffered rds are
// exported as pend_mask for the hazard unit.
// Optional: define WB_ARB_PERF_EN to add the perf_conflict/perf_stall/perf_kill
// event counters.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [4:0]        p_rd,
    input  logic [DATA_W-1:0] p_data,
    output logic              stall_w,
    input  logic              m_valid,
    input  logic [4:0]        m_rd,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef WB_ARB_PERF_EN
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_kill,
`endif
    output logic [31:0]       pend_mask
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(MAX_WAIT + 1);

    logic [FIFO_DEPTH-1:0] live_q, live_n;
    logic [4:0]            rd_q   [FIFO_DEPTH];
    logic [4:0]            rd_n   [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count;
    logic [SW-1:0]         starve;

    logic        full, empty, head_live, force_m, p_req;
    logic        grant_p, grant_m, pop, push;
    logic [31:0] pend_n;
    logic [31:0] kill_cnt;

    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Arbitration: starvation guard first, then pipeline priority, then the FIFO head.
    always_comb begin
        head_live = !empty && live_q[rd_ptr];
        force_m   = head_live && (starve == SW'(MAX_WAIT));
        p_req     = p_valid && (p_rd != 5'd0);
        grant_p   = p_req && !force_m;
        grant_m   = force_m || (head_live && !p_req);
        stall_w   = force_m && p_req;
        m_ready   = !rst && !full;
        // a dead head leaves without using the write port
        pop       = !empty && (grant_m || !live_q[rd_ptr]);
        push      = m_valid && !full;
    end

    // Next-state liveness: pop, then push, then WAW kill (which also covers the entry being pushed).
    always_comb begin
        live_n   = live_q;
        rd_n     = rd_q;
        pend_n   = '0;
        kill_cnt = '0;
        if (pop)
            live_n[rd_ptr] = 1'b0;
        if (push) begin
            live_n[wr_ptr] = (m_rd != 5'd0);
            rd_n[wr_ptr]   = m_rd;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (grant_p && live_n[i] && (rd_n[i] == p_rd)) begin
                live_n[i] = 1'b0;
                kill_cnt  = kill_cnt + 32'd1;
            end
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_n[i])
                pend_n[rd_n[i]] = 1'b1;
        end
        pend_n[0] = 1'b0;
    end

    // FIFO storage, pointers and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q <= live_n;
            rd_q   <= rd_n;
            if (push)
                data_q[wr_ptr] <= m_data;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (pop)
                starve <= '0;
            else if (head_live && !grant_m && (starve != SW'(MAX_WAIT)))
                starve <= starve + 1'b1;
        end
    end

    // Registered write port and pending-rd mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_wdata  <= '0;
            pend_mask <= '0;
        end else begin
            rf_we     <= grant_p || grant_m;
            pend_mask <= pend_n;
            if (grant_p) begin
                rf_rd    <= p_rd;
                rf_wdata <= p_data;
            end else if (grant_m) begin
                rf_rd    <= rd_q[rd_ptr];
                rf_wdata <= data_q[rd_ptr];
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    // Wrapping event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict <= '0;
            perf_stall    <= '0;
            perf_kill     <= '0;
        end else begin
            if (grant_p && head_live)
                perf_conflict <= perf_conflict + 32'd1;
            if (stall_w)
                perf_stall <= perf_stall + 32'd1;
            perf_kill <= perf_kill + kill_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int MW = 4;
    localparam int DEPTH = 2;

    logic          clk, rst;
    logic          p_valid, m_valid;
    logic [4:0]    p_rd, m_rd;
    logic [DW-1:0] p_data, m_data;
    logic          stall_w, m_ready, rf_we;
    logic [4:0]    rf_rd;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   pend_mask;
`ifdef WB_ARB_PERF_EN
    logic [31:0]   perf_conflict, perf_stall, perf_kill;
`endif

    wb_port_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .stall_w(stall_w),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef WB_ARB_PERF_EN
        .perf_conflict(perf_conflict), .perf_stall(perf_stall), .perf_kill(perf_kill),
`endif
        .pend_mask(pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerr = 0;

    // reference model
    typedef struct {
        bit        live;
        bit [4:0]  rd;
        bit [31:0] data;
    } ent_t;
    ent_t      q[$];
    int        starve;
    bit        e_we;
    bit [4:0]  e_rd;
    bit [31:0] e_wdata;
    bit [31:0] e_pend;
    bit        e_stall, e_ready;
    bit        o_stall, o_ready;
    int        m_conflict, m_stall, m_kill;

    function automatic void model_reset();
        q.delete();
        starve = 0;
        e_we = 0; e_rd = 0; e_wdata = 0; e_pend = 0;
        e_stall = 0; e_ready = 1;
        m_conflict = 0; m_stall = 0; m_kill = 0;
    endfunction

    // one clock cycle: apply inputs at the falling edge, sample the
    // combinational outputs, then advance the model across the rising edge
    task automatic cyc(input bit pv, input bit [4:0] prd, input bit [31:0] pd,
                       input bit mv, input bit [4:0] mrd, input bit [31:0] md);
        bit hl, frc, preq, gp, gm, pop, push;
        @(negedge clk);
        p_valid = pv; p_rd = prd; p_data = pd;
        m_valid = mv; m_rd = mrd; m_data = md;
        #1;
        o_stall = stall_w;
        o_ready = m_ready;
        hl   = (q.size() > 0) && q[0].live;
        frc  = hl && (starve == MW);
        preq = pv && (prd != 0);
        gp   = preq && !frc;
        gm   = frc || (hl && !preq);
        e_stall = frc && preq;
        e_ready = (q.size() < DEPTH);
        pop  = (q.size() > 0) && (gm || !q[0].live);
        push = mv && (q.size() < DEPTH);
        @(posedge clk);
        e_we = gp || gm;
        if (gp) begin
            e_rd = prd; e_wdata = pd;
        end else if (gm) begin
            e_rd = q[0].rd; e_wdata = q[0].data;
        end
        if (pop) starve = 0;
        else if (hl && !gm && starve < MW) starve++;
        if (gp && hl) m_conflict++;
        if (e_stall) m_stall++;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{live: (mrd != 0), rd: mrd, data: md});
        if (gp)
            foreach (q[i])
                if (q[i].live && q[i].rd == prd) begin
                    q[i].live = 0;
                    m_kill++;
                end
        e_pend = 0;
        foreach (q[i]) if (q[i].live) e_pend[q[i].rd] = 1'b1;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            cyc(0, 0, 0, 0, 0, 0);
            n++;
        end
        nchecks++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: model still holds %0d entries after %0d cycles, required 0", q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p_valid = 0; p_rd = 0; p_data = 0; m_valid = 0; m_rd = 0; m_data = 0;
        model_reset();
        #2;
        nchecks++;
        if ({rf_we, rf_rd, rf_wdata, pend_mask, stall_w, m_ready} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: we=%b rd=%0d wdata=%h pend=%h stall=%b ready=%b, required all 0",
                     rf_we, rf_rd, rf_wdata, pend_mask, stall_w, m_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nchecks++;
        if (m_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release_ready: got %b required 1", m_ready);
        end
    endtask

    task automatic test_single_m();
        drain();
        cyc(0, 0, 0, 1, 5, 32'hDEAD_BEEF);
        nchecks++;
        if (pend_mask !== 32'h20 || rf_we !== 1'b0) begin
            nerr++;
            $display("FAIL single_m_push: pend=%h we=%b, required pend=00000020 we=0", pend_mask, rf_we);
        end
        cyc(0, 0, 0, 0, 0, 0);
        nchecks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF || pend_mask !== 32'h0) begin
            nerr++;
            $display("FAIL single_m_write: we=%b rd=%0d wdata=%h pend=%h, required 1 5 deadbeef 0",
                     rf_we, rf_rd, rf_wdata, pend_mask);
        end
        cyc(0, 0, 0, 0, 0, 0);
        nchecks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            nerr++;
            $display("FAIL single_m_hold: we=%b rd=%0d wdata=%h, required 0 5 deadbeef", rf_we, rf_rd, rf_wdata);
        end
    endtask

    task automatic test_x0();
        drain();
        cyc(1, 0, 32'h1111, 1, 0, 32'h2222);
        nchecks++;
        if (o_stall !== 1'b0 || rf_we !== 1'b0 || pend_mask !== 32'h0) begin
            nerr++;
            $display("FAIL x0_req: stall=%b we=%b pend=%h, required 0 0 0", o_stall, rf_we, pend_mask);
        end
        cyc(0, 0, 0, 0, 0, 0);
        nchecks++;
        if (rf_we !== 1'b0 || pend_mask !== 32'h0 || q.size() != 0) begin
            nerr++;
            $display("FAIL x0_drop: we=%b pend=%h model_q=%0d, required 0 0 0", rf_we, pend_mask, q.size());
        end
    endtask

    task automatic test_starve();
        int stalls = 0, stall_at = -1, m_writes = 0;
        drain();
        cyc(1, 3, 32'hA000, 1, 7, 32'h7777);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 3, 32'hA001 + k, 0, 0, 0);
            nchecks++;
            if (o_stall !== e_stall || rf_we !== e_we || rf_rd !== e_rd || rf_wdata !== e_wdata) begin
                nerr++;
                $display("FAIL starve_cycle%0d: stall=%b we=%b rd=%0d data=%h, required %b %b %0d %h",
                         k, o_stall, rf_we, rf_rd, rf_wdata, e_stall, e_we, e_rd, e_wdata);
            end
            if (o_stall) begin
                stalls++;
                stall_at = k;
            end
            if (rf_we && rf_rd == 5'd7) m_writes++;
        end
        nchecks++;
        if (stalls != 1 || stall_at != MW || m_writes != 1) begin
            nerr++;
            $display("FAIL starve_guard: stalls=%0d at=%0d m_writes=%0d, required 1 at %0d with 1 write",
                     stalls, stall_at, m_writes, MW);
        end
    endtask

    task automatic test_full();
        int n = 0;
        bit acc = 0;
        drain();
        cyc(1, 3, 32'hB0, 1, 10, 32'h10);
        cyc(1, 3, 32'hB1, 1, 11, 32'h11);
        cyc(1, 3, 32'hB2, 1, 12, 32'h12);
        nchecks++;
        if (o_ready !== 1'b0 || pend_mask !== 32'h0000_0C00) begin
            nerr++;
            $display("FAIL full_block: ready=%b pend=%h, required 0 00000c00", o_ready, pend_mask);
        end
        while (!acc && n < 12) begin
            cyc(1, 3, 32'hB3 + n, 1, 12, 32'h12);
            acc = o_ready;
            n++;
            nchecks++;
            if (o_ready !== e_ready || o_stall !== e_stall || pend_mask !== e_pend) begin
                nerr++;
                $display("FAIL full_wait%0d: ready=%b stall=%b pend=%h, required %b %b %h",
                         n, o_ready, o_stall, pend_mask, e_ready, e_stall, e_pend);
            end
        end
        nchecks++;
        if (!acc) begin
            nerr++;
            $display("FAIL full_accept: third push not accepted within 12 cycles");
        end
    endtask

    task automatic test_kill();
        int k0 = m_kill;
        drain();
        cyc(1, 4, 32'h44, 1, 9, 32'h9999);
        nchecks++;
        if (pend_mask[9] !== 1'b1) begin
            nerr++;
            $display("FAIL kill_pend_set: pend=%h, bit 9 required 1", pend_mask);
        end
        cyc(1, 9, 32'h9090, 0, 0, 0);
        nchecks++;
        if (pend_mask[9] !== 1'b0 || rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h9090) begin
            nerr++;
            $display("FAIL kill_p_write: pend=%h we=%b rd=%0d data=%h, required bit9=0 1 9 9090",
                     pend_mask, rf_we, rf_rd, rf_wdata);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            nchecks++;
            if (rf_we !== 1'b0) begin
                nerr++;
                $display("FAIL kill_no_stale%0d: we=%b rd=%0d, required we=0", k, rf_we, rf_rd);
            end
        end
        nchecks++;
        if (m_kill - k0 != 1) begin
            nerr++;
            $display("FAIL kill_model_count: got %0d required 1", m_kill - k0);
        end
`ifdef WB_ARB_PERF_EN
        nchecks++;
        if (perf_kill !== 32'(m_kill) || perf_stall !== 32'(m_stall) || perf_conflict !== 32'(m_conflict)) begin
            nerr++;
            $display("FAIL perf_counters: kill=%0d stall=%0d conflict=%0d, required %0d %0d %0d",
                     perf_kill, perf_stall, perf_conflict, m_kill, m_stall, m_conflict);
        end
`endif
    endtask

    task automatic test_random();
        bit        pv = 0, mv = 0;
        bit [4:0]  prd = 0, mrd = 0;
        bit [31:0] pd = 0, md = 0;
        int        bad = 0;
        for (int k = 0; k < 400; k++) begin
            if (!(pv && e_stall)) begin
                pv = ($urandom_range(3) != 0);
                prd = 5'($urandom_range(3));
                pd = $urandom;
            end
            if (!(mv && !e_ready) || $urandom_range(7) == 0) begin
                mv = $urandom_range(1) != 0;
                mrd = 5'($urandom_range(3));
                md = $urandom;
            end
            cyc(pv, prd, pd, mv, mrd, md);
            nchecks++;
            if (o_stall !== e_stall || o_ready !== e_ready || rf_we !== e_we || rf_rd !== e_rd ||
                rf_wdata !== e_wdata || pend_mask !== e_pend) begin
                nerr++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: stall=%b ready=%b we=%b rd=%0d data=%h pend=%h, required %b %b %b %0d %h %h",
                             k, o_stall, o_ready, rf_we, rf_rd, rf_wdata, pend_mask,
                             e_stall, e_ready, e_we, e_rd, e_wdata, e_pend);
            end
        end
`ifdef WB_ARB_PERF_EN
        nchecks++;
        if (perf_kill !== 32'(m_kill) || perf_stall !== 32'(m_stall) || perf_conflict !== 32'(m_conflict)) begin
            nerr++;
            $display("FAIL random_perf: kill=%0d stall=%0d conflict=%0d, required %0d %0d %0d",
                     perf_kill, perf_stall, perf_conflict, m_kill, m_stall, m_conflict);
        end
`endif
    endtask

    task automatic test_mid_reset();
        drain();
        cyc(1, 3, 32'hC0, 1, 20, 32'h20);
        cyc(1, 3, 32'hC1, 1, 21, 32'h21);
        nchecks++;
        if (q.size() != 2 || pend_mask !== 32'h0030_0000) begin
            nerr++;
            $display("FAIL midrst_setup: model_q=%0d pend=%h, required 2 00300000", q.size(), pend_mask);
        end
        #2;
        rst = 1'b1;
        #1;
        nchecks++;
        if ({rf_we, rf_rd, rf_wdata, pend_mask, stall_w, m_ready} !== '0) begin
            nerr++;
            $display("FAIL midrst_async: we=%b rd=%0d wdata=%h pend=%h stall=%b ready=%b, required all 0",
                     rf_we, rf_rd, rf_wdata, pend_mask, stall_w, m_ready);
        end
        p_valid = 0; m_valid = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        nchecks++;
        if (m_ready !== 1'b1) begin
            nerr++;
            $display("FAIL midrst_ready: got %b required 1", m_ready);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            nchecks++;
            if (rf_we !== 1'b0 || pend_mask !== 32'h0) begin
                nerr++;
                $display("FAIL midrst_stale%0d: we=%b rd=%0d pend=%h, required we=0 pend=0",
                         k, rf_we, rf_rd, pend_mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_m();
        test_x0();
        test_starve();
        test_full();
        test_kill();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
